// File: rtl/reg64_serializer_pkg.sv
// Shared definitions for the 64-bit word serializer: word width, FSM encoding
// and the chunk-count helper used to size the chunk counter.
package reg64_serializer_pkg;

  localparam int WORD_W = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int num_chunks(input int chunk_w);
    return WORD_W / chunk_w;
  endfunction

endpackage

// File: rtl/reg64_serializer_if.sv
// Word-in / chunk-out valid-ready bundle. master = word source plus chunk sink,
// slave = the serializer.
interface reg64_serializer_if #(
  parameter int CHUNK_W = 8
);
  logic                                      in_valid;
  logic                                      in_ready;
  logic [reg64_serializer_pkg::WORD_W-1:0]   in_data;
  logic                                      out_valid;
  logic                                      out_ready;
  logic [CHUNK_W-1:0]                        out_data;
  logic                                      out_last;
  logic                                      busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/reg64_serializer.sv
// Parallel-to-serial unloader: takes one 64-bit word and emits it as
// 64/CHUNK_W chunks, reloading on the final chunk so words stream gap-free.
module reg64_serializer
  import reg64_serializer_pkg::*;
#(
  parameter int CHUNK_W   = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic               clk,
  input logic               reset,
  reg64_serializer_if.slave bus
);

  localparam int NUM_CHUNKS = num_chunks(CHUNK_W);
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

  if (!(CHUNK_W inside {1, 2, 4, 8, 16, 32, 64})) begin : g_bad_chunk_w
    $error("reg64_serializer: CHUNK_W=%0d is not a power of two dividing 64", CHUNK_W);
  end

  state_e            state, state_nxt;
  logic [WORD_W-1:0] sreg, sreg_nxt, shifted;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              last, out_xfer;

  // Next register image after one chunk leaves; vacated bits fill with zero.
  if (CHUNK_W == WORD_W) begin : g_shift_full
    assign shifted = '0;
  end else if (MSB_FIRST) begin : g_shift_left
    assign shifted = {sreg[WORD_W-CHUNK_W-1:0], {CHUNK_W{1'b0}}};
  end else begin : g_shift_right
    assign shifted = {{CHUNK_W{1'b0}}, sreg[WORD_W-1:CHUNK_W]};
  end

  assign last     = (state == SHIFT) && (cnt == LAST_CNT);
  assign out_xfer = (state == SHIFT) && bus.out_ready;

  // The only out_ready -> in_ready path: the final chunk leaving frees the register.
  assign bus.in_ready  = (state == IDLE) || (out_xfer && last);
  assign bus.out_valid = (state == SHIFT);
  assign bus.busy      = (state == SHIFT);
  assign bus.out_last  = last;
  assign bus.out_data  = MSB_FIRST ? sreg[WORD_W-1 -: CHUNK_W] : sreg[CHUNK_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          state_nxt = SHIFT;
          sreg_nxt  = bus.in_data;
          cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        if (out_xfer) begin
          if (!last) begin
            sreg_nxt = shifted;
            cnt_nxt  = cnt + 1'b1;
          end else if (bus.in_valid) begin
            sreg_nxt = bus.in_data;
            cnt_nxt  = '0;
          end else begin
            state_nxt = IDLE;
            sreg_nxt  = '0;
            cnt_nxt   = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg64_serializer.sv
// Bench for reg64_serializer: four configurations side by side, each checked
// every cycle against a queue-of-chunks model, plus literal directed checks.
module tb_reg64_serializer;

  localparam int NCFG = 4;
  localparam int CWS [NCFG] = '{8, 16, 64, 1};
  localparam int LOGSZ = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NCFG-1:0]        rst_a, in_valid_a, out_ready_a;
  logic [NCFG-1:0][63:0]  in_data_a;
  logic [NCFG-1:0]        ir_a, ov_a, ol_a, busy_a;
  logic [NCFG-1:0][63:0]  od_a;

  // Chunks observed on output transfers, with their last flags and cycle stamps.
  logic [63:0] logd [NCFG][LOGSZ];
  bit          logl [NCFG][LOGSZ];
  int          logc [NCFG][LOGSZ];
  int          logn [NCFG];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int CW = CWS[g];
    localparam bit MF = (g == 1);
    localparam int NC = 64 / CW;

    reg64_serializer_if #(.CHUNK_W(CW)) sif ();
    reg64_serializer #(.CHUNK_W(CW), .MSB_FIRST(MF)) dut (
      .clk  (clk),
      .reset(rst_a[g]),
      .bus  (sif)
    );

    assign sif.in_valid  = in_valid_a[g];
    assign sif.in_data   = in_data_a[g];
    assign sif.out_ready = out_ready_a[g];
    assign ir_a[g]   = sif.in_ready;
    assign ov_a[g]   = sif.out_valid;
    assign ol_a[g]   = sif.out_last;
    assign busy_a[g] = sif.busy;
    assign od_a[g]   = 64'(sif.out_data);

    // Model: pending chunks of accepted words, in emission order.
    logic [63:0] q  [$];
    bit          ql [$];

    always @(negedge clk) begin : model
      bit ev, ox, ei;
      logic [63:0] mask;
      int sh;
      if (!rst_a[g]) begin
        q.delete();
        ql.delete();
        chk($sformatf("cfg%0d rst out_valid", g), ov_a[g], 0);
        chk($sformatf("cfg%0d rst in_ready", g), ir_a[g], 1);
        chk($sformatf("cfg%0d rst busy", g), busy_a[g], 0);
        chk($sformatf("cfg%0d rst out_data", g), od_a[g], 0);
        chk($sformatf("cfg%0d rst out_last", g), ol_a[g], 0);
      end else begin
        ev = (q.size() != 0);
        ox = ev && out_ready_a[g];
        ei = !ev || (ox && ql[0]);
        chk($sformatf("cfg%0d out_valid", g), ov_a[g], ev);
        chk($sformatf("cfg%0d busy", g), busy_a[g], ev);
        chk($sformatf("cfg%0d in_ready", g), ir_a[g], ei);
        if (ev) begin
          chk($sformatf("cfg%0d out_data", g), od_a[g], q[0]);
          chk($sformatf("cfg%0d out_last", g), ol_a[g], ql[0]);
        end
        if (ox) begin
          if (logn[g] < LOGSZ) begin
            logd[g][logn[g]] = od_a[g];
            logl[g][logn[g]] = ol_a[g];
            logc[g][logn[g]] = cyc;
          end
          logn[g]++;
          void'(q.pop_front());
          void'(ql.pop_front());
        end
        if (in_valid_a[g] && ei) begin
          mask = (64'd1 << CW) - 64'd1;
          for (int i = 0; i < NC; i++) begin
            sh = MF ? 64 - (i + 1) * CW : i * CW;
            q.push_back((in_data_a[g] >> sh) & mask);
            ql.push_back(i == NC - 1);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int c, input logic [63:0] w);
    bit acc;
    int n;
    n = 0;
    in_valid_a[c] = 1'b1;
    in_data_a[c]  = w;
    do begin
      @(negedge clk);
      acc = ir_a[c];
      tick();
      n++;
    end while (!acc && n < 300);
    in_valid_a[c] = 1'b0;
    chk($sformatf("cfg%0d accept", c), acc, 1);
  endtask

  task automatic drain(input int c);
    bit b;
    int n;
    n = 0;
    do begin
      @(negedge clk);
      b = ov_a[c];
      tick();
      n++;
    end while (b && n < 300);
    chk($sformatf("cfg%0d drained", c), b, 0);
  endtask

  initial begin
    logic [63:0] w, asm;
    logic [63:0] exp16 [8];
    bit acc [NCFG];

    rst_a = '0;
    in_valid_a = '0;
    out_ready_a = '1;
    in_data_a = '0;
    for (int c = 0; c < NCFG; c++) logn[c] = 0;
    repeat (3) tick();
    rst_a = '1;
    repeat (2) tick();

    @(negedge clk);
    for (int c = 0; c < NCFG; c++) begin
      chk($sformatf("cfg%0d idle out_valid", c), ov_a[c], 0);
      chk($sformatf("cfg%0d idle in_ready", c), ir_a[c], 1);
      chk($sformatf("cfg%0d idle busy", c), busy_a[c], 0);
      chk($sformatf("cfg%0d idle out_data", c), od_a[c], 0);
    end
    tick();

    // Single word, LSB first.
    logn[0] = 0;
    send(0, 64'h0807060504030201);
    drain(0);
    chk("single count", logn[0], 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("single chunk%0d", i), logd[0][i], 64'(i + 1));
      chk($sformatf("single last%0d", i), logl[0][i], (i == 7));
    end
    chk("single contiguous", logc[0][7] - logc[0][0], 7);

    // Back-to-back, 16-bit MSB first.
    exp16 = '{64'hAAAA, 64'hBBBB, 64'hCCCC, 64'hDDDD, 64'h1111, 64'h2222, 64'h3333, 64'h4444};
    logn[1] = 0;
    send(1, 64'hAAAA_BBBB_CCCC_DDDD);
    send(1, 64'h1111_2222_3333_4444);
    drain(1);
    chk("b2b count", logn[1], 8);
    for (int i = 0; i < 8; i++) chk($sformatf("b2b chunk%0d", i), logd[1][i], exp16[i]);
    chk("b2b no gap", logc[1][4] - logc[1][3], 1);
    chk("b2b span", logc[1][7] - logc[1][0], 7);

    // Backpressure: stall while the third chunk is presented.
    logn[0] = 0;
    send(0, 64'h0807060504030201);
    tick();
    tick();
    out_ready_a[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp held data", od_a[0], 64'h03);
      chk("bp held valid", ov_a[0], 1);
      tick();
    end
    out_ready_a[0] = 1'b1;
    drain(0);
    chk("bp count", logn[0], 8);
    chk("bp chunk3", logd[0][2], 64'h03);
    chk("bp chunk4", logd[0][3], 64'h04);
    chk("bp stall gap", logc[0][2] - logc[0][1], 4);

    // Reset mid-word.
    send(0, 64'h1122334455667788);
    tick();
    tick();
    rst_a[0] = 1'b0;
    #1;
    chk("midrst out_valid", ov_a[0], 0);
    chk("midrst busy", busy_a[0], 0);
    tick();
    tick();
    rst_a[0] = 1'b1;
    tick();
    logn[0] = 0;
    send(0, '1);
    drain(0);
    chk("midrst count", logn[0], 8);
    for (int i = 0; i < 8; i++) chk($sformatf("midrst chunk%0d", i), logd[0][i], 64'hFF);

    // Degenerate 64-bit chunk.
    w = {$urandom, $urandom};
    logn[2] = 0;
    send(2, w);
    drain(2);
    chk("w64 count", logn[2], 1);
    chk("w64 data", logd[2][0], w);
    chk("w64 last", logl[2][0], 1);

    // Degenerate 1-bit chunk.
    w = {$urandom, $urandom};
    logn[3] = 0;
    send(3, w);
    drain(3);
    chk("w1 count", logn[3], 64);
    asm = '0;
    for (int i = 0; i < 64; i++) asm[i] = logd[3][i][0];
    chk("w1 word", asm, w);
    chk("w1 last63", logl[3][63], 1);
    chk("w1 last62", logl[3][62], 0);

    // Random traffic on all configurations.
    repeat (1500) begin
      @(negedge clk);
      for (int c = 0; c < NCFG; c++) acc[c] = in_valid_a[c] && ir_a[c] && rst_a[c];
      tick();
      for (int c = 0; c < NCFG; c++) begin
        if (acc[c] || !in_valid_a[c]) begin
          in_valid_a[c] = ($urandom_range(2) != 0);
          in_data_a[c]  = {$urandom, $urandom};
        end
        out_ready_a[c] = ($urandom_range(3) != 0);
        rst_a[c] = ($urandom_range(299) != 0);
      end
    end

    in_valid_a = '0;
    out_ready_a = '1;
    rst_a = '1;
    repeat (100) tick();
    @(negedge clk);
    for (int c = 0; c < NCFG; c++) chk($sformatf("cfg%0d final idle", c), ov_a[c], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg64_serializer.md
Name: reg64_serializer

Overview:
Parallel-to-serial unloader for 64-bit words held in the SoC's register stages. It accepts one 64-bit word over a valid/ready input handshake and emits it as NUM_CHUNKS = 64/CHUNK_W chunks over a valid/ready output handshake, flagging the final chunk. Consecutive words stream back-to-back with no bubble cycles.

Parameters:
CHUNK_W, 8, output chunk width in bits; legal values 1, 2, 4, 8, 16, 32, 64; any other value is an elaboration error.
MSB_FIRST, 0, 0 = emit the least-significant chunk first; 1 = emit the most-significant chunk first.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  reset; one clock; reset is asynchronous and active-low.
in_valid  input  1  in_data holds a word to load.
in_ready  output  1  block can accept a word this cycle.
in_data  input  64  parallel word.
out_valid  output  1  out_data holds a valid chunk.
out_ready  input  1  sink accepts the chunk this cycle.
out_data  output  CHUNK_W  current chunk.
out_last  output  1  current chunk is the final chunk of its word.
busy  output  1  a word is loaded and not fully drained.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, shift register=0, chunk counter=0; out_valid=0, out_data=0, out_last=0, busy=0. in_ready is 1 while in IDLE, including during reset. A word in flight when reset asserts is discarded with no partial output afterwards.
- Transfers: an input transfer happens on a clock edge where in_valid&in_ready=1. An output transfer happens on a clock edge where out_valid&out_ready=1.
- States:
  - IDLE: out_valid=0, in_ready=1. On an input transfer, load the shift register, set cnt=0 and go to SHIFT.
  - SHIFT: out_valid=1 and busy=1.
    - On an output transfer with out_last=0: shift by CHUNK_W toward the output end and increment cnt.
    - On an output transfer with out_last=1: if in_valid=1, load the new word in the same edge, set cnt=0 and stay in SHIFT. Otherwise go to IDLE.
- in_ready = (state==IDLE) | (out_valid & out_ready & out_last). This is the only combinational path from out_ready to in_ready. No other input-to-output combinational paths exist.
- Latency: a word accepted at edge k has its first chunk with out_valid=1 in the cycle after edge k.
- Throughput: one chunk per cycle while out_ready=1. Continuous streaming gives 64 bits every NUM_CHUNKS cycles.
- out_data comes directly from the register: the low CHUNK_W bits when MSB_FIRST=0, the high CHUNK_W bits when MSB_FIRST=1.
- out_last = (cnt == NUM_CHUNKS-1) while in SHIFT. cnt is $clog2(NUM_CHUNKS) bits wide, with a minimum width of 1.
- CHUNK_W=64 degenerates to one chunk per word with out_last=1 on every chunk.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_last and the internal state hold stable. out_valid never deasserts before its transfer completes.
- in_data is sampled only on an input transfer. in_valid is ignored when in_ready=0. A valid/ready protocol violation by the source is undefined; the block does not check for it.
- Vacated shift-register bits fill with 0.

Decomposition:
- Shared package holds:
  - WORD_W=64.
  - The state typedef/encoding (IDLE=1'b0, SHIFT=1'b1).
  - A function returning NUM_CHUNKS for a given CHUNK_W.
- No sub-module is needed. The shift register, counter and two-state FSM fit in a single module.

Test Plan:
- Reset then idle (CHUNK_W=8): release reset, in_valid=0 -> out_valid=0, in_ready=1, busy=0, out_data=0.
- Single word, LSB first (CHUNK_W=8, out_ready=1): in_data=64'h0807060504030201 -> out_data is 01,02,...,08 on 8 consecutive cycles starting the cycle after acceptance; out_last=1 only with 08; then IDLE.
- Back-to-back words (CHUNK_W=16, MSB_FIRST=1): words A=64'hAAAA_BBBB_CCCC_DDDD and B=64'h1111_2222_3333_4444 held valid -> 8 contiguous chunks AAAA,BBBB,CCCC,DDDD,1111,2222,3333,4444; in_ready pulses on DDDD's transfer edge; no gap cycle.
- Backpressure (CHUNK_W=8): drop out_ready for 3 cycles after the 3rd chunk -> out_data=03 and out_valid=1 held stable for those 3 cycles; the 4th chunk follows once out_ready rises; total chunk count stays 8.
- Reset mid-word: assert reset after 2 of 8 chunks -> out_valid=0 immediately (asynchronous); after release, new word 64'hFF..FF streams as 8×FF with no remnants of the old word.
- Degenerate widths: CHUNK_W=64 -> one chunk equal to in_data with out_last=1. CHUNK_W=1 -> 64 chunks matching in_data bit order; out_last=1 only on the 64th.
